button_event_reader: RTL and testbench

Input-side counterpart to the RGB colour sequencer. It reads one active-low board pushbutton, synchronises and debounces it, and emits single-cycle press, release, long-press and auto-repeat events. The colour stepping logic consumes these events to advance or hold LED colours.

---
 rtl/button_pkg.sv | 18 +
 rtl/sync_2ff.sv | 24 ++
 rtl/button_event_reader.sv | 184 ++++++++++++++++++
 tb/tb_button_event_reader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared state encoding and default timing for the pushbutton event reader.
// The defaults assume a 12 MHz clock.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    LONG,
    DB_RELEASE
  } btn_state_t;

  localparam int CLK_HZ                    = 12_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES   = CLK_HZ / 100;  // 10 ms
  localparam int DEFAULT_LONG_PRESS_CYCLES = CLK_HZ;        // 1 s
  localparam int DEFAULT_REPEAT_CYCLES     = CLK_HZ / 6;    // 1/6 s

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// The reset value lets an idle-high input come out of reset without a false edge.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= {2{RESET_VALUE}};
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/button_event_reader.sv
// Debounces an active-low pushbutton and turns it into press, release,
// long-press and auto-repeat single-cycle events plus a debounced level.
module button_event_reader
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic hold_active
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic btn_s;

  btn_state_t        state_reg, state_next;
  logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
  logic              long_flag_reg, long_flag_next;

  logic pressed_reg, pressed_next;
  logic press_reg, press_next;
  logic release_reg, release_next;
  logic long_reg, long_next;
  logic repeat_reg, repeat_next;
  logic hold_active_reg, hold_active_next;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_n),
    .q    (btn_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      db_cnt_reg      <= '0;
      hold_cnt_reg    <= '0;
      rep_cnt_reg     <= '0;
      long_flag_reg   <= 1'b0;
      pressed_reg     <= 1'b0;
      press_reg       <= 1'b0;
      release_reg     <= 1'b0;
      long_reg        <= 1'b0;
      repeat_reg      <= 1'b0;
      hold_active_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      db_cnt_reg      <= db_cnt_next;
      hold_cnt_reg    <= hold_cnt_next;
      rep_cnt_reg     <= rep_cnt_next;
      long_flag_reg   <= long_flag_next;
      pressed_reg     <= pressed_next;
      press_reg       <= press_next;
      release_reg     <= release_next;
      long_reg        <= long_next;
      repeat_reg      <= repeat_next;
      hold_active_reg <= hold_active_next;
    end
  end

  // hold_cnt and rep_cnt are left untouched in DB_RELEASE so a bounce resumes timing
  always_comb begin
    state_next     = state_reg;
    db_cnt_next    = db_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;
    rep_cnt_next   = rep_cnt_reg;
    long_flag_next = long_flag_reg;
    case (state_reg)
      IDLE: begin
        if (!btn_s) begin
          state_next  = DB_PRESS;
          db_cnt_next = '0;
        end
      end
      DB_PRESS: begin
        if (btn_s) begin
          state_next = IDLE;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next    = HELD;
          hold_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (btn_s) begin
          state_next  = DB_RELEASE;
          db_cnt_next = '0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next     = LONG;
          long_flag_next = 1'b1;
          rep_cnt_next   = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      LONG: begin
        if (btn_s) begin
          state_next  = DB_RELEASE;
          db_cnt_next = '0;
        end else if (rep_cnt_reg == REP_LAST) begin
          rep_cnt_next = '0;
        end else begin
          rep_cnt_next = rep_cnt_reg + 1'b1;
        end
      end
      DB_RELEASE: begin
        if (!btn_s) begin
          state_next = long_flag_reg ? LONG : HELD;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next     = IDLE;
          long_flag_next = 1'b0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pressed_next     = pressed_reg;
    hold_active_next = hold_active_reg;
    press_next       = 1'b0;
    release_next     = 1'b0;
    long_next        = 1'b0;
    repeat_next      = 1'b0;
    case (state_reg)
      DB_PRESS: begin
        if (!btn_s && db_cnt_reg == DB_LAST) begin
          pressed_next = 1'b1;
          press_next   = 1'b1;
        end
      end
      HELD: begin
        if (!btn_s && hold_cnt_reg == HOLD_LAST) begin
          long_next        = 1'b1;
          hold_active_next = 1'b1;
        end
      end
      LONG: begin
        if (!btn_s && rep_cnt_reg == REP_LAST) begin
          repeat_next = 1'b1;
        end
      end
      DB_RELEASE: begin
        if (btn_s && db_cnt_reg == DB_LAST) begin
          pressed_next     = 1'b0;
          release_next     = 1'b1;
          hold_active_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign pressed       = pressed_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_pulse    = long_reg;
  assign repeat_pulse  = repeat_reg;
  assign hold_active   = hold_active_reg;

endmodule

// File: tb/tb_button_event_reader.sv
// Self-checking bench: run-length reference model compared every cycle, a
// segment table with expected event counts, exact-latency sequences and random bursts.
module tb_button_event_reader;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_n = 1'b1;
  logic pressed, press_pulse, release_pulse, long_pulse, repeat_pulse, hold_active;

  always #5 clk = ~clk;

  button_event_reader #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES    (R)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_n        (btn_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .hold_active  (hold_active)
  );

  int checks = 0;
  int fails = 0;
  int cycle_no = 0;
  int n_press = 0, n_release = 0, n_long = 0, n_repeat = 0;

  // Reference model: the button is accepted after D+1 consecutive synchronised
  // samples at the new level; hold/repeat time counts only undisturbed held samples.
  logic m_s1 = 1'b1, m_s2 = 1'b1;
  logic m_pressed = 1'b0, m_long = 1'b0;
  logic m_press, m_rel, m_longp, m_repp;
  int   m_run = 0, m_hold = 0, m_rep = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cycle_no, act, exp);
    end
  endtask

  task automatic model_step();
    logic b;
    m_press = 1'b0; m_rel = 1'b0; m_longp = 1'b0; m_repp = 1'b0;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_pressed = 1'b0; m_long = 1'b0;
      m_run = 0; m_hold = 0; m_rep = 0;
    end else begin
      b = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_n;
      if (!m_pressed) begin
        if (!b) m_run++; else m_run = 0;
        if (m_run == D + 1) begin
          m_pressed = 1'b1; m_press = 1'b1; m_run = 0; m_hold = 0;
        end
      end else if (b) begin
        m_run++;
        if (m_run == D + 1) begin
          m_pressed = 1'b0; m_rel = 1'b1; m_long = 1'b0; m_run = 0;
        end
      end else begin
        if (m_run == 0) begin
          if (!m_long) begin
            m_hold++;
            if (m_hold == L) begin m_long = 1'b1; m_longp = 1'b1; m_rep = 0; end
          end else begin
            m_rep++;
            if (m_rep == R) begin m_rep = 0; m_repp = 1'b1; end
          end
        end
        m_run = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cycle_no++;
    check("model", {26'd0, pressed, press_pulse, release_pulse, long_pulse, repeat_pulse, hold_active},
          {26'd0, m_pressed, m_press, m_rel, m_longp, m_repp, m_long});
    n_press   += int'(press_pulse);
    n_release += int'(release_pulse);
    n_long    += int'(long_pulse);
    n_repeat  += int'(repeat_pulse);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0: return press_pulse;
      1: return release_pulse;
      2: return long_pulse;
      default: return repeat_pulse;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, output int k);
    k = 0;
    while (k < budget) begin
      tick();
      k++;
      if (pick(sel)) break;
    end
  endtask

  typedef struct {
    logic rst_n;
    logic btn_n;
    int   cycles;
    int   press;
    int   rel;
    int   lng;
    int   rep;
    logic pressed;
    logic hold;
  } seg_t;

  seg_t tbl[17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, p0, r0, l0, q0;
    tbl[0]  = '{1'b1, 1'b1, 10, 0, 0, 0, 0, 1'b0, 1'b0};  // idle
    tbl[1]  = '{1'b1, 1'b0, 15, 1, 0, 0, 0, 1'b1, 1'b0};  // clean press
    tbl[2]  = '{1'b1, 1'b1, 12, 0, 1, 0, 0, 1'b0, 1'b0};  // clean release
    tbl[3]  = '{1'b1, 1'b0,  3, 0, 0, 0, 0, 1'b0, 1'b0};  // glitch
    tbl[4]  = '{1'b1, 1'b1, 10, 0, 0, 0, 0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 60, 1, 0, 1, 6, 1'b1, 1'b1};  // long hold
    tbl[6]  = '{1'b1, 1'b1, 10, 0, 1, 0, 1, 1'b0, 1'b0};  // one late repeat, then release
    tbl[7]  = '{1'b1, 1'b0, 15, 1, 0, 0, 0, 1'b1, 1'b0};  // release bounce
    tbl[8]  = '{1'b1, 1'b1,  2, 0, 0, 0, 0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 30, 0, 0, 1, 3, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 10, 0, 1, 0, 0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 24, 1, 0, 0, 0, 1'b1, 1'b0};  // release on hold_cnt=L-1
    tbl[12] = '{1'b1, 1'b1, 10, 0, 1, 0, 0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 35, 1, 0, 1, 1, 1'b1, 1'b1};  // reset mid-LONG
    tbl[14] = '{1'b0, 1'b0,  1, 0, 0, 0, 0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 10, 1, 0, 0, 0, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 12, 0, 1, 0, 0, 1'b0, 1'b0};

    rst_n = 1'b0;
    btn_n = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {26'd0, pressed, press_pulse, release_pulse, long_pulse, repeat_pulse, hold_active}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      p0 = n_press; r0 = n_release; l0 = n_long; q0 = n_repeat;
      rst_n = tbl[i].rst_n;
      btn_n = tbl[i].btn_n;
      repeat (tbl[i].cycles) tick();
      check($sformatf("seg%0d_press", i),   n_press - p0,   tbl[i].press);
      check($sformatf("seg%0d_release", i), n_release - r0, tbl[i].rel);
      check($sformatf("seg%0d_long", i),    n_long - l0,    tbl[i].lng);
      check($sformatf("seg%0d_repeat", i),  n_repeat - q0,  tbl[i].rep);
      check($sformatf("seg%0d_pressed", i), {31'd0, pressed},     {31'd0, tbl[i].pressed});
      check($sformatf("seg%0d_hold", i),    {31'd0, hold_active}, {31'd0, tbl[i].hold});
      $display("segment %0d: rst_n=%0b btn_n=%0b cycles=%0d events p/r/l/q=%0d/%0d/%0d/%0d",
               i, tbl[i].rst_n, tbl[i].btn_n, tbl[i].cycles,
               n_press - p0, n_release - r0, n_long - l0, n_repeat - q0);
    end

    // Exact latencies of each event
    rst_n = 1'b1;
    btn_n = 1'b1;
    repeat (5) tick();
    btn_n = 1'b0;
    wait_for(0, 30, k);
    check("press_latency", k, D + 3);
    check("pressed_after_press", {31'd0, pressed}, 32'd1);
    wait_for(2, 40, k);
    check("long_after_press", k, L);
    check("hold_active_on_long", {31'd0, hold_active}, 32'd1);
    wait_for(3, 20, k);
    check("first_repeat", k, R);
    wait_for(3, 20, k);
    check("repeat_period", k, R);
    btn_n = 1'b1;
    wait_for(1, 30, k);
    check("release_latency", k, D + 3);
    check("hold_cleared_with_release", {30'd0, pressed, hold_active}, 32'd0);
    $display("latency sequence done at cycle %0d", cycle_no);

    // Reset while in long hold, button kept low
    repeat (5) tick();
    btn_n = 1'b0;
    wait_for(2, 60, k);
    r0 = n_release;
    rst_n = 1'b0;
    tick();
    check("reset_mid_long", {26'd0, pressed, press_pulse, release_pulse, long_pulse, repeat_pulse, hold_active}, 32'd0);
    rst_n = 1'b1;
    wait_for(0, 30, k);
    check("repress_latency", k, D + 3);
    check("no_release_on_reset", n_release - r0, 0);
    btn_n = 1'b1;
    wait_for(1, 30, k);
    $display("reset-in-long sequence done at cycle %0d", cycle_no);

    // Random bursts with occasional reset
    for (int i = 0; i < 60; i++) begin
      int len;
      rst_n = ($urandom_range(0, 19) != 0);
      btn_n = 1'($urandom_range(0, 1));
      len = rst_n ? int'($urandom_range(1, 35)) : 1;
      repeat (len) tick();
      $display("random burst %0d: rst_n=%0b btn_n=%0b len=%0d", i, rst_n, btn_n, len);
    end
    rst_n = 1'b1;
    btn_n = 1'b1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
